cpubus_master: RTL



---
 rtl/cpubus_master.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/cpubus_master.sv
//------------------------------------------------------------------------------
// Module   : cpubus_master
// Purpose  : Wishbone classic slave that issues single-beat 68040-style CPU
//            bus cycles (TS/TIP/SIZ/TT/RW, multiplexed AD, TA/TEA termination).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpubus_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        bclk,
    input  logic        reset,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [29:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [31:0] bus_ad_o,
    input  logic [31:0] bus_ad_i,
    output logic        bus_ad_t,
    output logic        bus_ts,
    output logic        bus_tip,
    output logic        bus_rw,
    output logic [1:0]  bus_siz,
    output logic [1:0]  bus_tt,
    input  logic        bus_ta,
    input  logic        bus_tea
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    state_t      r_state, w_state;
    logic        r_ts, w_ts;
    logic        r_tip, w_tip;
    logic        r_ad_t, w_ad_t;
    logic        r_rw, w_rw;
    logic [1:0]  r_siz, w_siz;
    logic [31:0] r_ad_o, w_ad_o;
    logic        r_ack, w_ack;
    logic        r_err, w_err;
    logic [31:0] r_dat_o, w_dat_o;
    logic [7:0]  r_cnt, w_cnt;
    logic        r_we, w_we;
    logic [31:0] r_wdat, w_wdat;
    logic        r_abandon, w_abandon;

    logic        w_sel_ok;
    logic [1:0]  w_siz_dec;
    logic [1:0]  w_a_dec;
    logic [7:0]  w_cnt_inc;

    assign w_cnt_inc = r_cnt + 8'd1;

    // Big-endian lane decode: sel bit 3 is AD[31:24], i.e. byte offset 0.
    always_comb begin
        w_sel_ok  = 1'b1;
        w_siz_dec = 2'b00;
        w_a_dec   = 2'b00;
        case (wb_sel_i)
            4'b1000: begin w_siz_dec = 2'b01; w_a_dec = 2'b00; end
            4'b0100: begin w_siz_dec = 2'b01; w_a_dec = 2'b01; end
            4'b0010: begin w_siz_dec = 2'b01; w_a_dec = 2'b10; end
            4'b0001: begin w_siz_dec = 2'b01; w_a_dec = 2'b11; end
            4'b1100: begin w_siz_dec = 2'b10; w_a_dec = 2'b00; end
            4'b0011: begin w_siz_dec = 2'b10; w_a_dec = 2'b10; end
            4'b1111: begin w_siz_dec = 2'b00; w_a_dec = 2'b00; end
            default: w_sel_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_state   = r_state;
        w_ts      = 1'b1;
        w_tip     = 1'b1;
        w_ad_t    = 1'b1;
        w_rw      = 1'b1;
        w_siz     = r_siz;
        w_ad_o    = r_ad_o;
        w_ack     = 1'b0;
        w_err     = 1'b0;
        w_dat_o   = r_dat_o;
        w_cnt     = r_cnt;
        w_we      = r_we;
        w_wdat    = r_wdat;
        w_abandon = r_abandon;

        case (r_state)
            ST_IDLE: begin
                // r_err blocks re-sampling the same rejected request while
                // the master is still seeing its error pulse.
                if (wb_cyc_i && wb_stb_i && !r_err) begin
                    if (!w_sel_ok) begin
                        w_err = 1'b1;
                    end else begin
                        w_state   = ST_ADDR;
                        w_ts      = 1'b0;
                        w_tip     = 1'b0;
                        w_ad_t    = 1'b0;
                        w_ad_o    = {wb_adr_i, w_a_dec};
                        w_rw      = ~wb_we_i;
                        w_siz     = w_siz_dec;
                        w_we      = wb_we_i;
                        w_wdat    = wb_dat_i;
                        w_abandon = 1'b0;
                    end
                end
            end

            ST_ADDR: begin
                w_state   = ST_DATA;
                w_tip     = 1'b0;
                w_rw      = r_rw;
                w_cnt     = 8'd0;
                w_abandon = r_abandon | ~wb_cyc_i;
                if (r_we) begin
                    w_ad_t = 1'b0;
                    w_ad_o = r_wdat;
                end
            end

            ST_DATA: begin
                w_tip     = 1'b0;
                w_rw      = r_rw;
                w_ad_t    = r_ad_t;
                w_cnt     = w_cnt_inc;
                w_abandon = r_abandon | ~wb_cyc_i;
                if (!bus_tea || !bus_ta || (w_cnt_inc == c_timeout)) begin
                    w_state = ST_DONE;
                    w_tip   = 1'b1;
                    w_ad_t  = 1'b1;
                    w_rw    = 1'b1;
                    // TEA has priority; timeout also lands in the error path.
                    if (bus_tea && !bus_ta) begin
                        if (!r_we) begin
                            w_dat_o = bus_ad_i;
                        end
                        w_ack = ~w_abandon;
                    end else begin
                        w_err = ~w_abandon;
                    end
                end
            end

            ST_DONE: begin
                w_state = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge bclk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ts      <= 1'b1;
            r_tip     <= 1'b1;
            r_ad_t    <= 1'b1;
            r_rw      <= 1'b1;
            r_siz     <= 2'b00;
            r_ad_o    <= 32'd0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_dat_o   <= 32'd0;
            r_cnt     <= 8'd0;
            r_we      <= 1'b0;
            r_wdat    <= 32'd0;
            r_abandon <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ts      <= w_ts;
            r_tip     <= w_tip;
            r_ad_t    <= w_ad_t;
            r_rw      <= w_rw;
            r_siz     <= w_siz;
            r_ad_o    <= w_ad_o;
            r_ack     <= w_ack;
            r_err     <= w_err;
            r_dat_o   <= w_dat_o;
            r_cnt     <= w_cnt;
            r_we      <= w_we;
            r_wdat    <= w_wdat;
            r_abandon <= w_abandon;
        end
    end

    assign wb_dat_o = r_dat_o;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign bus_ad_o = r_ad_o;
    assign bus_ad_t = r_ad_t;
    assign bus_ts   = r_ts;
    assign bus_tip  = r_tip;
    assign bus_rw   = r_rw;
    assign bus_siz  = r_siz;
    assign bus_tt   = 2'b00;

endmodule

`default_nettype wire
